// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared DSP types and helpers for the CFO-correction front end
// (phase_accum) and the CORDIC rotator it feeds.
//
// Contents:
//   amp_t / arg_t   : signed sample component / signed phase argument
//   PI, PI_2        : phase constants, full scale 2^(2W) == 2*pi
//   rot_word_t      : rotator input word {phase, q, i}
//   pack_rot()      : builds a rotator input word
//   pa_state_t      : packet-tracking state of the phase accumulator
//   LFSR_SEED,
//   lfsr16_next()   : x^16+x^14+x^13+x^11+1 maximal LFSR step (phase dither)
// -----------------------------------------------------------------------------
package dsp_pkg;

  localparam int DSP_W = 16;

  typedef logic signed [DSP_W-1:0]   amp_t;
  typedef logic signed [2*DSP_W-1:0] arg_t;
  typedef logic        [4*DSP_W-1:0] rot_word_t;

  // Half and quarter turn; MSB alone is pi because full scale is 2*pi.
  localparam arg_t PI   = arg_t'({1'b1,  {(2*DSP_W-1){1'b0}}});
  localparam arg_t PI_2 = arg_t'({2'b01, {(2*DSP_W-2){1'b0}}});

  typedef enum logic {
    ST_IDLE = 1'b0,   // between packets, acc sits at 0
    ST_BUSY = 1'b1    // inside a packet
  } pa_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic rot_word_t pack_rot(arg_t ph, amp_t q, amp_t i);
    return {ph, q, i};
  endfunction

  // Fibonacci form, taps 16/14/13/11 -> bits 15/13/12/10.
  function automatic logic [15:0] lfsr16_next(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/phase_accum_if.sv
// -----------------------------------------------------------------------------
// phase_accum_if
// Packetised valid/ready stream used on both sides of phase_accum.
//
// Signals:
//   valid : beat valid (source)
//   ready : beat accepted when valid && ready on clk edge (sink)
//   data  : DW-bit payload (source)
//   last  : last beat of packet (source)
// Modports: master = source side, slave = sink side.
// -----------------------------------------------------------------------------
interface phase_accum_if #(
  parameter int DW = 32
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Two-entry output buffer: a main register driving the output plus one skid
// register that absorbs the beat arriving in the cycle the sink stalls.
// Input ready depends only on skid occupancy and reset, so it is registered
// with respect to the input side and breaks the ready path.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : upstream beat valid
//   o_ready    : upstream ready (= !skid_full && !reset)
//   i_data     : upstream payload, DW bits
//   o_valid    : downstream valid (main register full)
//   i_ready    : downstream ready
//   o_data     : downstream payload, held while o_valid && !i_ready
// -----------------------------------------------------------------------------
module skid_buffer
  import dsp_pkg::*;
#(
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] r_main, r_skid;
  logic          r_main_full, r_skid_full;
  logic          w_push, w_pop;

  assign o_ready = !r_skid_full && !reset;
  assign o_valid = r_main_full;
  assign o_data  = r_main;

  assign w_push = i_valid && o_ready;
  assign w_pop  = r_main_full && i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main      <= '0;
      r_skid      <= '0;
      r_main_full <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (r_skid_full) begin
      // No push possible here; a pop refills main from the older skid beat.
      if (w_pop) begin
        r_main      <= r_skid;
        r_skid_full <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_main_full || w_pop) begin
        r_main      <= i_data;
        r_main_full <= 1'b1;
      end else begin
        r_skid      <= i_data;
        r_skid_full <= 1'b1;
      end
    end else if (w_pop) begin
      r_main_full <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_accum.sv
// -----------------------------------------------------------------------------
// phase_accum
// CFO-correction feeder for the CORDIC rotator. Tags each I/Q sample with a
// wrapping phase that restarts at 0 every packet and advances by the active
// frequency word per sample. New frequency words are held pending and only
// take effect at packet boundaries, so a packet never sees two frequencies.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   s          : input stream, data = {q, i} (2*WIDTH), last = end of packet
//   m          : output stream, data = {phase, q, i} (4*WIDTH), last delayed
//   cfg_valid  : frequency word write strobe
//   cfg_freq   : signed phase increment per sample (2*WIDTH), 2^(2W) = 2*pi
//
// Optional build macro PHASE_DITHER_EN: adds the low DITHER_BITS of a 16-bit
// LFSR to the emitted phase (acc itself stays clean) to break up truncation
// spurs in the rotator. Without it, emitted phase equals acc exactly.
// -----------------------------------------------------------------------------
module phase_accum
  import dsp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DITHER_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  phase_accum_if.slave       s,
  phase_accum_if.master      m,
  input  logic               cfg_valid,
  input  logic [2*WIDTH-1:0] cfg_freq
);

  localparam int PW = 2 * WIDTH;       // phase / frequency width
  localparam int OW = 4 * WIDTH + 1;   // {last, phase, q, i}

  pa_state_t        r_state, w_state_nxt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_freq_active;
  logic [PW-1:0]    r_pending;
  logic             r_pend_vld;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_idle_apply;
  logic             w_last_apply;
  logic [DITHER_BITS-1:0] w_dither;
  logic [PW-1:0]    w_phase;
  logic [OW-1:0]    w_in_word;
  logic [OW-1:0]    w_out_word;
  logic             w_out_valid;

  assign w_accept     = s.valid && w_in_ready;
  assign w_last_apply = w_accept && s.last;
  assign w_idle_apply = (r_state == ST_IDLE) && !w_accept;

  // ---------------------------------------------------------------------------
  // Packet tracking FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = s.last ? ST_IDLE : ST_BUSY;
  end

  // ---------------------------------------------------------------------------
  // Phase accumulator: emit acc, then step; the last sample rewinds to 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)         r_acc <= '0;
    else if (w_accept) r_acc <= s.last ? '0 : r_acc + r_freq_active;
  end

  // ---------------------------------------------------------------------------
  // Frequency update. A write landing on the s_last edge is forwarded straight
  // into freq_active so it governs the very next packet. A write landing on
  // the first sample of a packet just parks in pending until that packet ends.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq_active <= '0;
      r_pending     <= '0;
      r_pend_vld    <= 1'b0;
    end else if (w_last_apply) begin
      if (cfg_valid)       r_freq_active <= cfg_freq;
      else if (r_pend_vld) r_freq_active <= r_pending;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_idle_apply && r_pend_vld) r_freq_active <= r_pending;
      if (cfg_valid) begin
        r_pending  <= cfg_freq;
        r_pend_vld <= 1'b1;
      end else if (w_idle_apply) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output phase dither
  // ---------------------------------------------------------------------------
`ifdef PHASE_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset)         r_lfsr <= LFSR_SEED;
    else if (w_accept) r_lfsr <= lfsr16_next(r_lfsr);
  end

  assign w_dither = r_lfsr[DITHER_BITS-1:0];
`else
  assign w_dither = '0;
`endif

  assign w_phase = r_acc + PW'(w_dither);

  // ---------------------------------------------------------------------------
  // Output buffering
  // ---------------------------------------------------------------------------
  assign w_in_word = {s.last, w_phase, s.data};

  skid_buffer #(.DW(OW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (s.valid),
    .o_ready (w_in_ready),
    .i_data  (w_in_word),
    .o_valid (w_out_valid),
    .i_ready (m.ready),
    .o_data  (w_out_word)
  );

  assign s.ready = w_in_ready;
  assign m.valid = w_out_valid;
  assign m.last  = w_out_word[OW-1];
  assign m.data  = w_out_word[OW-2:0];

endmodule

// File: tb/tb_phase_accum.sv
module tb_phase_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [31:0] cfg_freq;

  always #5 clk = ~clk;

  phase_accum_if #(.DW(32)) s_if ();
  phase_accum_if #(.DW(64)) m_if ();

  phase_accum #(.WIDTH(16), .DITHER_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (s_if),
    .m         (m_if),
    .cfg_valid (cfg_valid),
    .cfg_freq  (cfg_freq)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  // drive image, applied at each negedge by cycle()
  logic        d_reset, d_valid, d_last, d_cfg_v, d_mready;
  logic [31:0] d_data, d_cfg_f;

  // observations
  logic        o_sready, o_mvalid, o_mlast, last_acc;
  logic [63:0] o_mdata;
  beat_t       obs_q[$];
  beat_t       exp_q[$];
  int          n_acc, stall_viol;
  logic        prev_stall, prev_last;
  logic [63:0] prev_data;

  // reference model: phase of k-th sample in a packet = k * packet frequency
  logic [31:0] m_active, m_pend, m_pktf;
  logic        m_pv, m_inpkt;
  int unsigned m_k;

  int n_chk = 0;
  int n_fail = 0;

  task automatic model_clear();
    obs_q.delete(); exp_q.delete();
    m_active = '0; m_pend = '0; m_pv = 1'b0; m_inpkt = 1'b0; m_k = 0;
    prev_stall = 1'b0;
  endtask

  task automatic cycle();
    beat_t b;
    logic [31:0] ph;
    @(negedge clk);
    reset = d_reset; s_if.valid = d_valid; s_if.data = d_data; s_if.last = d_last;
    cfg_valid = d_cfg_v; cfg_freq = d_cfg_f; m_if.ready = d_mready;
    #1;
    o_sready = s_if.ready; o_mvalid = m_if.valid; o_mdata = m_if.data; o_mlast = m_if.last;
    last_acc = 1'b0;
    if (d_reset) begin
      model_clear();
    end else begin
      if (prev_stall && (!o_mvalid || o_mdata !== prev_data || o_mlast !== prev_last))
        stall_viol++;
      prev_stall = o_mvalid && !d_mready;
      prev_data  = o_mdata;
      prev_last  = o_mlast;
      if (o_mvalid && d_mready) begin
        b.data = o_mdata; b.last = o_mlast; obs_q.push_back(b);
      end
      if (d_valid && o_sready) begin
        last_acc = 1'b1; n_acc++;
        if (m_k == 0) m_pktf = m_active;
        ph = 32'(m_k) * m_pktf;
        b.data = {ph, d_data}; b.last = d_last; exp_q.push_back(b);
        if (d_last) begin
          m_k = 0; m_inpkt = 1'b0;
          if (d_cfg_v)   m_active = d_cfg_f;
          else if (m_pv) m_active = m_pend;
          m_pv = 1'b0;
        end else begin
          m_k++; m_inpkt = 1'b1;
          if (d_cfg_v) begin m_pend = d_cfg_f; m_pv = 1'b1; end
        end
      end else begin
        if (!m_inpkt && m_pv) begin m_active = m_pend; m_pv = 1'b0; end
        if (d_cfg_v) begin m_pend = d_cfg_f; m_pv = 1'b1; end
      end
    end
  endtask

  task automatic set_freq(input logic [31:0] f);
    d_valid = 1'b0; d_cfg_v = 1'b1; d_cfg_f = f; cycle();
    d_cfg_v = 1'b0; cycle();
  endtask

  task automatic send(input logic [31:0] d, input logic last,
                      input logic cv, input logic [31:0] cf);
    d_valid = 1'b1; d_data = d; d_last = last; d_cfg_v = cv; d_cfg_f = cf;
    for (int t = 0; t < 64; t++) begin
      cycle();
      d_cfg_v = 1'b0;
      if (last_acc) break;
    end
    n_chk++;
    if (!last_acc) begin
      n_fail++; $display("FAIL send_timeout: sample %h not accepted in 64 cycles", d);
    end
    d_valid = 1'b0;
  endtask

  task automatic drain();
    d_valid = 1'b0; d_cfg_v = 1'b0; d_mready = 1'b1;
    repeat (5) cycle();
  endtask

  task automatic test_reset();
    d_reset = 1'b1; d_mready = 1'b1; d_valid = 1'b0; d_cfg_v = 1'b0;
    cycle();
    n_chk++; if (o_sready !== 1'b0) begin n_fail++; $display("FAIL reset_sready: got %b want 0", o_sready); end
    cycle();
    d_reset = 1'b0; cycle();
    n_chk++; if (o_mvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b want 0", o_mvalid); end
    n_chk++; if (o_mlast !== 1'b0) begin n_fail++; $display("FAIL reset_mlast: got %b want 0", o_mlast); end
    n_chk++; if (o_sready !== 1'b1) begin n_fail++; $display("FAIL reset_sready_after: got %b want 1", o_sready); end
  endtask

  task automatic test_increment();
    logic [31:0] tbl [4] = '{32'h0, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    set_freq(32'h1000_0000);
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) send($urandom, k == 3, 1'b0, '0);
    drain();
    n_chk++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL inc_count: got %0d want 4", obs_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k].data[63:32] !== tbl[k]) begin n_fail++; $display("FAIL inc_phase[%0d]: got %h want %h", k, obs_q[k].data[63:32], tbl[k]); end
      n_chk++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL inc_beat[%0d]: got %h/%b want %h/%b", k, obs_q[k].data, obs_q[k].last, exp_q[k].data, exp_q[k].last); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] tbl [5] = '{32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0};
    set_freq(32'h8000_0000);
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 5; k++) send($urandom, k == 4, 1'b0, '0);
    drain();
    n_chk++; if (obs_q.size() != 5) begin n_fail++; $display("FAIL wrap_count: got %0d want 5", obs_q.size()); end
    for (int k = 0; k < 5 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k].data[63:32] !== tbl[k]) begin n_fail++; $display("FAIL wrap_phase[%0d]: got %h want %h", k, obs_q[k].data[63:32], tbl[k]); end
      n_chk++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL wrap_beat[%0d]: got %h want %h", k, obs_q[k].data, exp_q[k].data); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] smp [6];
    int idx, a0;
    foreach (smp[k]) smp[k] = $urandom;
    obs_q.delete(); exp_q.delete(); stall_viol = 0;
    d_mready = 1'b0; d_cfg_v = 1'b0; idx = 0; a0 = n_acc;
    for (int c = 0; c < 3; c++) begin
      d_valid = 1'b1; d_data = smp[idx]; d_last = (idx == 5);
      cycle();
      if (last_acc) idx++;
    end
    n_chk++; if (n_acc - a0 != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", n_acc - a0); end
    n_chk++; if (o_sready !== 1'b0) begin n_fail++; $display("FAIL bp_sready: got %b want 0", o_sready); end
    d_mready = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      d_valid = 1'b1; d_data = smp[idx]; d_last = (idx == 5);
      cycle();
      if (last_acc) idx++;
    end
    drain();
    n_chk++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", obs_q.size()); end
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k].data[31:0] !== smp[k] || obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", k, obs_q[k].data, exp_q[k].data); end
    end
    n_chk++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d stall violations want 0", stall_viol); end
  endtask

  task automatic test_mid_cfg();
    logic [31:0] tbl [7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd2, 32'd4};
    set_freq(32'd1);
    obs_q.delete(); exp_q.delete();
    send($urandom, 1'b0, 1'b0, '0);
    send($urandom, 1'b0, 1'b0, '0);
    d_valid = 1'b0; d_cfg_v = 1'b1; d_cfg_f = 32'd2; cycle(); d_cfg_v = 1'b0;
    send($urandom, 1'b0, 1'b0, '0);
    send($urandom, 1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) send($urandom, k == 2, 1'b0, '0);
    drain();
    n_chk++; if (obs_q.size() != 7) begin n_fail++; $display("FAIL mid_count: got %0d want 7", obs_q.size()); end
    for (int k = 0; k < 7 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k].data[63:32] !== tbl[k] || obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL mid_phase[%0d]: got %h want %h", k, obs_q[k].data[63:32], tbl[k]); end
    end
  endtask

  task automatic test_coincident();
    logic [31:0] tbl [9] = '{32'd0, 32'd2, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd7, 32'd14};
    set_freq(32'd2);
    obs_q.delete(); exp_q.delete();
    send($urandom, 1'b0, 1'b0, '0);
    send($urandom, 1'b1, 1'b1, 32'd5);   // cfg lands with s_last
    send($urandom, 1'b1, 1'b0, '0);      // single-sample packet
    send($urandom, 1'b0, 1'b0, '0);
    send($urandom, 1'b1, 1'b0, '0);
    send($urandom, 1'b1, 1'b0, '0);      // single-sample, must leave block idle
    set_freq(32'd7);
    for (int k = 0; k < 3; k++) send($urandom, k == 2, 1'b0, '0);
    drain();
    n_chk++; if (obs_q.size() != 9) begin n_fail++; $display("FAIL coin_count: got %0d want 9", obs_q.size()); end
    for (int k = 0; k < 9 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k].data[63:32] !== tbl[k] || obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL coin_phase[%0d]: got %h want %h", k, obs_q[k].data[63:32], tbl[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] tbl [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
    set_freq(32'd3);
    d_mready = 1'b1;
    send($urandom, 1'b0, 1'b0, '0);
    send($urandom, 1'b0, 1'b0, '0);
    d_reset = 1'b1; d_valid = 1'b1; d_data = $urandom; d_last = 1'b0; cycle();
    d_reset = 1'b0; d_valid = 1'b0; cycle();
    n_chk++; if (o_mvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mvalid: got %b want 0", o_mvalid); end
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 3; k++) send($urandom, k == 2, 1'b0, '0);
    set_freq(32'd4);
    for (int k = 0; k < 2; k++) send($urandom, k == 1, 1'b0, '0);
    drain();
    n_chk++; if (obs_q.size() != 5) begin n_fail++; $display("FAIL rstmid_count: got %0d want 5", obs_q.size()); end
    for (int k = 0; k < 5 && k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[k].data[63:32] !== tbl[k] || obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rstmid_phase[%0d]: got %h want %h", k, obs_q[k].data[63:32], tbl[k]); end
    end
  endtask

  task automatic test_random();
    obs_q.delete(); exp_q.delete(); stall_viol = 0;
    d_valid = 1'b0; last_acc = 1'b0;
    repeat (400) begin
      if (!d_valid || last_acc) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_data  = $urandom;
        d_last  = ($urandom_range(0, 4) == 0);
      end
      d_mready = ($urandom_range(0, 3) != 0);
      d_cfg_v  = ($urandom_range(0, 9) == 0);
      d_cfg_f  = $urandom;
      cycle();
    end
    drain();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_chk++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_beat[%0d]: got %h/%b want %h/%b", k, obs_q[k].data, obs_q[k].last, exp_q[k].data, exp_q[k].last); end
    end
    n_chk++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand_stable: got %0d stall violations want 0", stall_viol); end
  endtask

  initial begin
    reset = 1'b1; s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0;
    m_if.ready = 1'b1; cfg_valid = 1'b0; cfg_freq = '0;
    d_reset = 1'b1; d_valid = 1'b0; d_data = '0; d_last = 1'b0;
    d_cfg_v = 1'b0; d_cfg_f = '0; d_mready = 1'b1;
    n_acc = 0; stall_viol = 0;
    model_clear();
    test_reset();
    test_increment();
    test_wrap();
    test_backpressure();
    test_mid_cfg();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
